pwm_generator: RTL and testbench
================================

// Module: pwm_generator
// PURPOSE
// - Free-running PWM source, one per servo channel in the robot arm controller.
// - Output is high for RISE clock cycles, then low for FALL cycles; period = RISE+FALL.
// - Servo use at 50 MHz: rise+fall = 1,000,000 (20 ms); rise 50,000..100,000 (1-2 ms).
// - Duty values are resampled only at period boundaries, so a change never glitches the current period.
// PARAMETERS
// - WIDTH  32  width of rise/fall inputs; internal counter is WIDTH+1 bits
// PORTS
// - clk      in   1      system clock (50 MHz)
// - reset_n  in   1      asynchronous reset, active-low
// - rise     in   WIDTH  high-time in clock cycles (unsigned)
// - fall     in   WIDTH  low-time in clock cycles (unsigned)
// - out      out  1      registered PWM output
// BEHAVIOUR
// - One clock. Reset is asynchronous and active-low.
// - Reset state: cnt=0, rise_q=0, fall_q=0, out=0.
//   - out drops to 0 immediately on reset_n falling, mid-period included.
// - Internal state:
//   - rise_q, fall_q: shadow copies of rise and fall.
//   - period = rise_q + fall_q, computed in WIDTH+1 bits (no wrap).
//   - cnt: WIDTH+1-bit position in the current period.
// - Each posedge with reset_n=1, end-of-period check (cnt+1 >= period):
//   - true: rise_q<=rise; fall_q<=fall; cnt<=0; out<=(rise!=0).
//   - false: cnt<=cnt+1; out<=(cnt+1 < rise_q).
// - After reset, the first edge always loads, because period=0.
//   - The first high cycle of out starts at the first edge after reset_n rises.
// - Steady state: out high exactly rise_q cycles, then low exactly fall_q cycles; repeats.
// - Input changes mid-period are ignored until the next load edge.
//   - Load edge = edge after the last cycle of the current period.
// - Boundaries:
//   - rise=0, fall>0: out constantly 0.
//   - rise>0, fall=0: out constantly 1.
//   - rise=0, fall=0: out 0; reloads every cycle, so any nonzero input takes effect on the next edge.
//   - rise=fall=2^WIDTH-1: period 2^(WIDTH+1)-2, no overflow.
// - Latency: input to output, at most one full old period plus 1 cycle.
// - No handshake; inputs are assumed stable relative to clk (same-clock registers).
// TESTING
// - rise=3, fall=2 after reset: out = 1,1,1,0,0 repeating from the first edge after reset_n high.
// - rise=100000, fall=900000: high pulse 100000 cycles, rising edges 1,000,000 cycles apart.
// - rise=3,fall=2; change to rise=1,fall=1 at cycle 1 of a period:
//   - current period finishes as 1,1,1,0,0, then 1,0,1,0...
// - rise=0,fall=5 -> out stays 0; rise=5,fall=0 -> out stays 1 after the first load.
// - Assert reset_n=0 during the high phase -> out=0 asynchronously.
//   - On release, the period restarts with a full rise-length high.
// - rise=0,fall=0 for 10 cycles, then rise=2,fall=2:
//   - out 0, then 1,1,0,0 starting on the next edge.

Source files
------------

// File: rtl/pwm_generator.sv
// Free-running PWM source: out high for rise cycles, then low for fall cycles, repeating.
// Latency: an input change shows up at out within one full old period plus one cycle.
// Backpressure: none; rise/fall are sampled only at period boundaries, so no glitches.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset; forces out low immediately
//   rise     high-time in clock cycles (unsigned)
//   fall     low-time in clock cycles (unsigned)
//   out      registered PWM output
module pwm_generator #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] rise,
  input  logic [WIDTH-1:0] fall,
  output logic             out
);

  // Shadow copies of the duty inputs, held for one whole period.
  logic [WIDTH-1:0] r_rise_q;
  logic [WIDTH-1:0] r_fall_q;
  // Position inside the current period.
  logic [WIDTH:0]   r_cnt;
  logic             r_out;

  logic [WIDTH:0]   w_period;
  logic [WIDTH:0]   w_cnt_nxt;
  logic             w_load;

  // One extra bit so that rise+fall never wraps, even at all-ones inputs.
  assign w_period  = {1'b0, r_rise_q} + {1'b0, r_fall_q};
  // r_cnt never exceeds period-1, so the increment cannot overflow.
  assign w_cnt_nxt = r_cnt + {{WIDTH{1'b0}}, 1'b1};
  // A zero period (fresh reset, or rise=fall=0) loads on every edge.
  assign w_load    = (w_cnt_nxt >= w_period);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rise_q <= '0;
      r_fall_q <= '0;
      r_cnt    <= '0;
      r_out    <= 1'b0;
    end else if (w_load) begin
      r_rise_q <= rise;
      r_fall_q <= fall;
      r_cnt    <= '0;
      // Position 0 of the new period is high unless the high-time is zero.
      r_out    <= (rise != '0);
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_out    <= (w_cnt_nxt < {1'b0, r_rise_q});
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_pwm_generator.sv
module tb_pwm_generator;

  localparam int W = 32;

  logic         clk     = 1'b0;
  logic         reset_n = 1'b1;
  logic [W-1:0] rise    = '0;
  logic [W-1:0] fall    = '0;
  logic         out;

  // Narrow instance exercising the all-ones boundary: 7+7 = 14 needs the extra bit.
  logic [2:0]   s_rise  = 3'd7;
  logic [2:0]   s_fall  = 3'd7;
  logic         s_out;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pwm_generator #(.WIDTH(W)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rise    (rise),
    .fall    (fall),
    .out     (out)
  );

  pwm_generator #(.WIDTH(3)) u_small (
    .clk     (clk),
    .reset_n (reset_n),
    .rise    (s_rise),
    .fall    (s_fall),
    .out     (s_out)
  );

  task automatic chk(input string nm, input logic got, input logic exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at t=%0t", nm, got, exp, $time);
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", nm, got, exp, $time);
  endtask

  task automatic sample(output logic v);
    @(posedge clk);
    #1;
    v = out;
  endtask

  // Checks the next n post-edge samples of out against v, MSB first.
  task automatic expect_seq(input string nm, input int n, input logic [31:0] v);
    logic cur;
    for (int i = 0; i < n; i++) begin
      sample(cur);
      chk(nm, cur, v[n-1-i]);
    end
  endtask

  // Reference model: a period is a run of rise_q ones followed by fall_q zeros.
  // When both runs are used up, the inputs seen at that edge start a new period.
  longint rem_hi  = 0;
  longint rem_lo  = 0;
  int     small_k = 0;

  initial begin
    forever begin
      logic [W-1:0] r;
      logic [W-1:0] f;
      logic         rst;
      logic         e;
      logic         e_s;
      @(posedge clk);
      r   = rise;
      f   = fall;
      rst = reset_n;
      #1;
      if (!rst) begin
        rem_hi  = 0;
        rem_lo  = 0;
        small_k = 0;
        e       = 1'b0;
        e_s     = 1'b0;
      end else begin
        if (rem_hi == 0 && rem_lo == 0) begin
          rem_hi = longint'(r);
          rem_lo = longint'(f);
        end
        if (rem_hi > 0) begin
          e = 1'b1;
          rem_hi--;
        end else if (rem_lo > 0) begin
          e = 1'b0;
          rem_lo--;
        end else begin
          e = 1'b0;
        end
        e_s = ((small_k % 14) < 7);
        small_k++;
      end
      chk("model_out", out, e);
      chk("small_out", s_out, e_s);
    end
  end

  initial begin
    logic cur;
    logic prev;
    bit   found;
    int   hi_len;
    int   per_len;

    // Reset state.
    rise = 32'd3;
    fall = 32'd2;
    #2 reset_n = 1'b0;
    #2;
    chk("reset_out", out, 1'b0);
    chk("reset_small_out", s_out, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // rise=3, fall=2: 1,1,1,0,0 repeating from the first edge.
    expect_seq("r3f2", 10, 32'b1110011100);

    // Change to 1/1 one cycle into a period: old period completes first.
    expect_seq("mid_p0", 1, 32'b1);
    @(negedge clk);
    rise = 32'd1;
    fall = 32'd1;
    expect_seq("mid_change", 8, 32'b11001010);

    // rise=0: constantly low.
    @(negedge clk);
    rise = 32'd0;
    fall = 32'd5;
    repeat (10) @(posedge clk);
    expect_seq("r0f5", 5, 32'b00000);

    // fall=0: constantly high.
    @(negedge clk);
    rise = 32'd5;
    fall = 32'd0;
    repeat (10) @(posedge clk);
    expect_seq("r5f0", 5, 32'b11111);

    // Asynchronous reset during the high phase, then full-length restart.
    @(negedge clk);
    rise    = 32'd4;
    fall    = 32'd4;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    expect_seq("pre_arst", 2, 32'b11);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_mid_high", out, 1'b0);
    chk("arst_small", s_out, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    expect_seq("post_arst", 8, 32'b11110000);

    // rise=fall=0 idles low and reloads every cycle.
    @(negedge clk);
    rise = 32'd0;
    fall = 32'd0;
    repeat (20) @(posedge clk);
    expect_seq("r0f0", 3, 32'b000);
    @(negedge clk);
    rise = 32'd2;
    fall = 32'd2;
    expect_seq("from_zero", 6, 32'b110011);

    // Scaled servo pulse: 1000 high in a 10000-cycle period.
    @(negedge clk);
    rise = 32'd1000;
    fall = 32'd9000;
    repeat (20) @(posedge clk);
    found = 1'b0;
    sample(prev);
    for (int i = 0; i < 20000 && !found; i++) begin
      sample(cur);
      if (prev === 1'b0 && cur === 1'b1) found = 1'b1;
      prev = cur;
    end
    chk_int("servo_edge_found", int'(found), 1);
    hi_len  = 1;
    per_len = 1;
    if (found) begin
      for (int i = 0; i < 20000; i++) begin
        sample(cur);
        if (cur === 1'b1 && per_len == hi_len) begin
          hi_len++;
          per_len++;
        end else if (cur === 1'b0) begin
          per_len++;
        end else begin
          break;
        end
      end
    end
    chk_int("servo_high_len", hi_len, 1000);
    chk_int("servo_period", per_len, 10000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
